// File: rtl/forward_hazard_ctrl.sv
// rtl/forward_hazard_ctrl.sv - EX-stage operand forwarding selects and load-use hazard control
//
// Purpose: shadows the EX/MEM destination registers of the 5-stage pipeline,
// produces registered forwarding-mux selects for the instruction entering EX,
// and stalls PC/IF-ID with a bubble into EX on a load-use dependency.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   id_valid_i, id_rs1_i/rs2_i,   ID-stage instruction fields
//   id_rd_i, id_regwrite_i,
//   id_memread_i
//   flush_i                       discard ID instruction (bubble into EX)
//   freeze_i                      hold all state this cycle
//   stall_o                       hold PC and IF/ID, bubble into EX
//   fwd_a_o, fwd_b_o              00 regfile, 01 MEM/WB, 10 EX/MEM
//   ex_valid_o                    EX holds a real instruction
//   stall_cnt_o                   saturating count of load-use stall cycles
module forward_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {RUN, BUBBLE, FROZEN} state_e;

    state_e state_q, state_d;
    state_e resume_q, resume_d;   // state to return to when a freeze lifts
    state_e cur_state;

    // Source-register fields of the EX instruction are never consulted again
    // once its selects are registered, so only producer fields are shadowed.
    logic              ex_valid_q, ex_regwrite_q, ex_memread_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              mem_valid_q, mem_regwrite_q;
    logic [REG_AW-1:0] mem_rd_q;

    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use, stall, bubble_in;

    // x0 is hardwired, so a producer with rd = 0 never forwards.
    function automatic logic hit(input logic v, input logic rw,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] src);
        return v && rw && (rd != '0) && (rd == src);
    endfunction

    function automatic logic [1:0] sel(input logic [REG_AW-1:0] src,
                                       input logic ex_v, input logic ex_rw,
                                       input logic [REG_AW-1:0] ex_rd,
                                       input logic mem_v, input logic mem_rw,
                                       input logic [REG_AW-1:0] mem_rd);
        // The current EX producer will be in EX/MEM when src reaches EX and
        // is the most recent writer, so it beats the MEM producer.
        if (hit(ex_v, ex_rw, ex_rd, src))
            return 2'b10;
        else if (hit(mem_v, mem_rw, mem_rd, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        load_use  = id_valid_i && ex_memread_q &&
                    (hit(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rs1_i) ||
                     hit(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rs2_i));
        stall     = load_use && !freeze_i && !flush_i;
        bubble_in = stall || flush_i || !id_valid_i;

        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!bubble_in) begin
            fwd_a_d = sel(id_rs1_i, ex_valid_q, ex_regwrite_q, ex_rd_q,
                          mem_valid_q, mem_regwrite_q, mem_rd_q);
            fwd_b_d = sel(id_rs2_i, ex_valid_q, ex_regwrite_q, ex_rd_q,
                          mem_valid_q, mem_regwrite_q, mem_rd_q);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        cur_state = (state_q == FROZEN) ? resume_q : state_q;
        if (freeze_i) begin
            if (state_q != FROZEN)
                resume_d = state_q;
            state_d = FROZEN;
        end else begin
            case (cur_state)
                RUN:     state_d = stall ? BUBBLE : RUN;
                BUBBLE:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q        <= RUN;
            resume_q       <= RUN;
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            fwd_a_q        <= 2'b00;
            fwd_b_q        <= 2'b00;
            stall_cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            if (!freeze_i) begin
                mem_valid_q    <= ex_valid_q;
                mem_regwrite_q <= ex_regwrite_q;
                mem_rd_q       <= ex_rd_q;
                ex_valid_q     <= !bubble_in;
                ex_regwrite_q  <= !bubble_in && id_regwrite_i;
                ex_memread_q   <= !bubble_in && id_memread_i;
                ex_rd_q        <= bubble_in ? '0 : id_rd_i;
                fwd_a_q        <= fwd_a_d;
                fwd_b_q        <= fwd_b_d;
                stall_cnt_q    <= stall_cnt_d;
            end
        end
    end

    assign stall_o     = stall;
    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign ex_valid_o  = ex_valid_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb/tb_forward_hazard_ctrl.sv - self-checking bench for forward_hazard_ctrl
module tb_forward_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_regwrite = 1'b0, id_memread = 1'b0;
    logic             flush = 1'b0, freeze = 1'b0;
    logic             stall;
    logic [1:0]       fwd_a, fwd_b;
    logic             ex_valid;
    logic [CNT_W-1:0] stall_cnt;

    forward_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .flush_i(flush), .freeze_i(freeze),
        .stall_o(stall), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .ex_valid_o(ex_valid), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: slot[0] is the instruction in EX, slot[1] one stage older
    // (EX/MEM), slot[2] two stages older (MEM/WB).
    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       rw, mr;
    } ins_t;

    ins_t slot [3];
    int   m_cnt;
    int   checks = 0;
    int   errors = 0;
    int   o_stall, o_fa, o_fb, o_exv, o_cnt;

    function automatic bit writes(ins_t p, bit [4:0] r);
        return p.v && p.rw && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic int exp_fwd(bit [4:0] r);
        if (!slot[0].v)            return 0;
        if (writes(slot[1], r))    return 2;
        if (writes(slot[2], r))    return 1;
        return 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, clock, advance model.
    task automatic cyc(input bit v, input int r1, input int r2, input int d,
                       input bit rw, input bit mr,
                       input bit fl = 0, input bit fz = 0, input bit rs = 1);
        bit   e_stall;
        ins_t nxt;
        id_valid = v; id_rs1 = r1[4:0]; id_rs2 = r2[4:0]; id_rd = d[4:0];
        id_regwrite = rw; id_memread = mr; flush = fl; freeze = fz; rst = rs;
        #3;
        e_stall = v && !fz && !fl && slot[0].mr &&
                  (writes(slot[0], id_rs1) || writes(slot[0], id_rs2));
        o_stall = int'(stall); o_fa = int'(fwd_a); o_fb = int'(fwd_b);
        o_exv = int'(ex_valid); o_cnt = int'(stall_cnt);
        chk("stall", o_stall, int'(e_stall));
        chk("fwd_a", o_fa, exp_fwd(slot[0].rs1));
        chk("fwd_b", o_fb, exp_fwd(slot[0].rs2));
        chk("ex_valid", o_exv, int'(slot[0].v));
        chk("stall_cnt", o_cnt, m_cnt);
        @(posedge clk);
        if (!rs) begin
            for (int i = 0; i < 3; i++) slot[i] = '{default: 0};
            m_cnt = 0;
        end else if (!fz) begin
            nxt = '{default: 0};
            if (!(e_stall || fl || !v))
                nxt = '{v: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd, rw: rw, mr: mr};
            slot[2] = slot[1];
            slot[1] = slot[0];
            slot[0] = nxt;
            if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        #1;
    endtask

    task automatic nop(input bit rs = 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, rs);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) slot[i] = '{default: 0};
        m_cnt = 0;
        @(posedge clk); #1;
        nop(0); nop(0);

        // Reset state
        nop();
        chk("rst_fwd_a", o_fa, 0); chk("rst_exv", o_exv, 0);
        chk("rst_cnt", o_cnt, 0);  chk("rst_stall", o_stall, 0);

        // T1 ALU chain
        cyc(1, 1, 2, 5, 1, 0);
        cyc(1, 5, 3, 8, 1, 0);
        nop();
        chk("t1_fwd_a", o_fa, 2); chk("t1_exv", o_exv, 1);

        // T2 gap of one
        cyc(1, 1, 2, 5, 1, 0);
        nop();
        cyc(1, 3, 5, 9, 1, 0);
        nop();
        chk("t2_fwd_b", o_fb, 1); chk("t2_fwd_a", o_fa, 0);

        // T3 load-use
        cyc(1, 2, 0, 6, 1, 1);
        cyc(1, 6, 0, 10, 1, 0);
        chk("t3_stall", o_stall, 1);
        cyc(1, 6, 0, 10, 1, 0);
        chk("t3_stall_drop", o_stall, 0); chk("t3_bubble", o_exv, 0);
        chk("t3_cnt", o_cnt, 1);
        nop();
        chk("t3_fwd_a", o_fa, 1); chk("t3_exv", o_exv, 1);

        // T4 double match
        cyc(1, 1, 2, 7, 1, 0);
        cyc(1, 7, 1, 7, 1, 0);
        cyc(1, 7, 7, 11, 1, 0);
        nop();
        chk("t4_fwd_a", o_fa, 2); chk("t4_fwd_b", o_fb, 2);

        // T5 x0 never forwarded; flush beats load-use
        cyc(1, 1, 2, 0, 1, 0);
        cyc(1, 0, 4, 12, 1, 0);
        nop();
        chk("t5_x0_a", o_fa, 0);
        cyc(1, 2, 0, 6, 1, 1);
        cyc(1, 6, 0, 10, 1, 0, 1);
        chk("t5_flush_stall", o_stall, 0);
        nop();
        chk("t5_flush_bubble", o_exv, 0); chk("t5_cnt", o_cnt, 1);

        // T6 freeze mid-chain
        cyc(1, 1, 2, 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 3, 8, 1, 0, 0, 1);
            chk("t6_frz_exv", o_exv, 1);
        end
        cyc(1, 5, 3, 8, 1, 0);
        nop();
        chk("t6_resume_fwd_a", o_fa, 2);

        // Freeze suppresses load-use, then reset during BUBBLE
        cyc(1, 1, 0, 6, 1, 1);
        cyc(1, 6, 0, 10, 1, 0, 0, 1);
        chk("t6_frz_stall", o_stall, 0);
        cyc(1, 6, 0, 10, 1, 0);
        chk("t6_stall", o_stall, 1); chk("t6_cnt", o_cnt, 1);
        cyc(1, 6, 0, 10, 1, 0, 0, 0, 0);
        nop();
        chk("t6_rst_exv", o_exv, 0); chk("t6_rst_cnt", o_cnt, 0);
        chk("t6_rst_fwd_a", o_fa, 0);

        // Reset while stall_o is high
        cyc(1, 1, 0, 6, 1, 1);
        cyc(1, 6, 0, 10, 1, 0, 0, 0, 0);
        chk("rst_mid_stall", o_stall, 1);
        cyc(1, 6, 0, 10, 1, 0);
        chk("rst_stall_drop", o_stall, 0);

        // Counter saturation at 2^CNT_W-1
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 6, 1, 1);
            cyc(1, 3, 6, 10, 1, 0);
            cyc(1, 3, 6, 10, 1, 0);
        end
        nop();
        chk("sat_cnt", o_cnt, 15);

        // Mixed traffic against the model
        rst = 1'b1;
        nop(0);
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 49) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
